// File: rtl/led_scan_ctrl_pkg.sv
// Shared types and width helpers for the LED scan controller and its column shifter.
package led_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_LATCH   = 2'd2,
        ST_DISPLAY = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2
    } shift_phase_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int addr_width(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

    function automatic int row_width(input int rows);
        return clog2_min1(rows);
    endfunction

    function automatic int plane_width(input int pwm_bits);
        return clog2_min1(pwm_bits);
    endfunction

    // Sized for the longest dwell (top bit-plane) plus one bit of headroom.
    function automatic int dwell_width(input int dwell, input int pwm_bits);
        return $clog2(dwell << (pwm_bits - 1)) + 1;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// Frame-buffer read port: strobe and address out, pixel intensity back one clock later.
interface led_scan_ctrl_if #(
    parameter int ADDR_W = led_scan_pkg::addr_width(8, 16),
    parameter int DATA_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/led_scan_ctrl_col_shifter.sv
// Column shifter: walks one row's columns in three phases (read, capture bit, clock out)
// and raises o_done during the final phase of the last column.
module led_col_shifter
    import led_scan_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 16,
    parameter int PWM_BITS = 4,
    localparam int ADDR_W  = addr_width(ROWS, COLS),
    localparam int ROW_W   = row_width(ROWS),
    localparam int PLANE_W = plane_width(PWM_BITS)
) (
    input  logic               i_clk,
    input  logic               i_RESET_n,
    input  logic               i_abort,
    input  logic               i_start,
    input  logic [ROW_W-1:0]   i_row,
    input  logic [PLANE_W-1:0] i_plane,
    output logic               o_done,
    led_scan_ctrl_if.master    fb,
    output logic               o_sclk,
    output logic               o_sdata
);
    localparam int COL_W = clog2_min1(COLS);

    shift_phase_t      r_phase;
    logic              r_active;
    logic [COL_W-1:0]  r_col;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_sdata;
    logic              r_sclk;
    logic              w_last_col;

    assign w_last_col = (r_col == COL_W'(COLS - 1));
    assign o_done     = r_active && (r_phase == PH_P2) && w_last_col;

    always_ff @(posedge i_clk or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_active  <= 1'b0;
            r_phase   <= PH_P0;
            r_col     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_sdata   <= 1'b0;
            r_sclk    <= 1'b0;
        end else if (i_abort) begin
            r_active  <= 1'b0;
            r_phase   <= PH_P0;
            r_col     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_sdata   <= 1'b0;
            r_sclk    <= 1'b0;
        end else if (i_start) begin
            r_active  <= 1'b1;
            r_phase   <= PH_P0;
            r_col     <= '0;
            r_rd_en   <= 1'b1;
            r_rd_addr <= ADDR_W'(i_row) * ADDR_W'(COLS);
            r_sclk    <= 1'b0;
        end else if (r_active) begin
            // The shift clock is registered out of P2, so it rises a full cycle after sdata settles.
            r_sclk <= (r_phase == PH_P2);
            case (r_phase)
                PH_P0: begin
                    r_rd_en <= 1'b0;
                    r_phase <= PH_P1;
                end
                PH_P1: begin
                    r_sdata <= fb.rd_data[i_plane];
                    r_phase <= PH_P2;
                end
                PH_P2: begin
                    r_phase <= PH_P0;
                    if (w_last_col) begin
                        r_active <= 1'b0;
                    end else begin
                        r_col     <= r_col + COL_W'(1);
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                default: r_phase <= PH_P0;
            endcase
        end else begin
            r_sclk <= 1'b0;
        end
    end

    assign fb.rd_en   = r_rd_en;
    assign fb.rd_addr = r_rd_addr;
    assign o_sclk     = r_sclk;
    assign o_sdata    = r_sdata;

endmodule

// File: rtl/led_scan_ctrl.sv
// LED array scan controller: bit-angle-modulated row scanning driven from the frame buffer.
//   state      | meaning
//   ST_IDLE    | panel blanked, waiting for i_ena
//   ST_SHIFT   | column shifter clocks one bit-plane of the current row
//   ST_LATCH   | one-clock latch strobe, row select updated
//   ST_DISPLAY | row lit for DWELL<<plane clocks
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 16,
    parameter int PWM_BITS = 4,
    parameter int DWELL    = 16,
    localparam int ROW_W   = row_width(ROWS)
) (
    input  logic             i_clk,
    input  logic             i_RESET_n,
    input  logic             i_ena,
    led_scan_ctrl_if.master  fb,
    output logic             o_sclk,
    output logic             o_sdata,
    output logic             o_latch,
    output logic             o_blank_n,
    output logic [ROW_W-1:0] o_row,
    output logic             o_frame_start
);
    localparam int PLANE_W = plane_width(PWM_BITS);
    localparam int DWELL_W = dwell_width(DWELL, PWM_BITS);

    scan_state_t        r_state, w_state_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [ROW_W-1:0]   r_row_out, w_row_out_nxt;
    logic [PLANE_W-1:0] r_plane, w_plane_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic [DWELL_W-1:0] w_dwell_load;
    logic               r_latch, w_latch_nxt;
    logic               r_blank_n, w_blank_n_nxt;
    logic               r_frame_start, w_frame_start_nxt;
    logic               w_start;
    logic               w_done;
    logic               w_abort;

    assign w_abort      = !i_ena;
    assign w_dwell_load = DWELL_W'((DWELL << r_plane) - 1);

    always_comb begin
        w_state_nxt       = r_state;
        w_row_nxt         = r_row;
        w_row_out_nxt     = r_row_out;
        w_plane_nxt       = r_plane;
        w_dwell_nxt       = r_dwell;
        w_latch_nxt       = 1'b0;
        w_blank_n_nxt     = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_start           = 1'b0;
        if (w_abort) begin
            w_state_nxt   = ST_IDLE;
            w_row_nxt     = '0;
            w_row_out_nxt = '0;
            w_plane_nxt   = '0;
            w_dwell_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_SHIFT;
                    w_row_nxt         = '0;
                    w_plane_nxt       = '0;
                    w_start           = 1'b1;
                    w_frame_start_nxt = 1'b1;
                end
                ST_SHIFT: begin
                    if (w_done) begin
                        w_state_nxt   = ST_LATCH;
                        w_latch_nxt   = 1'b1;
                        w_row_out_nxt = r_row;
                    end
                end
                ST_LATCH: begin
                    w_state_nxt   = ST_DISPLAY;
                    w_blank_n_nxt = 1'b1;
                    w_dwell_nxt   = w_dwell_load;
                end
                ST_DISPLAY: begin
                    if (r_dwell == '0) begin
                        w_state_nxt = ST_SHIFT;
                        w_start     = 1'b1;
                        if (r_plane == PLANE_W'(PWM_BITS - 1)) begin
                            w_plane_nxt = '0;
                            if (r_row == ROW_W'(ROWS - 1)) begin
                                w_row_nxt         = '0;
                                w_frame_start_nxt = 1'b1;
                            end else begin
                                w_row_nxt = r_row + ROW_W'(1);
                            end
                        end else begin
                            w_plane_nxt = r_plane + PLANE_W'(1);
                        end
                    end else begin
                        w_dwell_nxt   = r_dwell - DWELL_W'(1);
                        w_blank_n_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_row_out     <= '0;
            r_plane       <= '0;
            r_dwell       <= '0;
            r_latch       <= 1'b0;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_row_out     <= w_row_out_nxt;
            r_plane       <= w_plane_nxt;
            r_dwell       <= w_dwell_nxt;
            r_latch       <= w_latch_nxt;
            r_blank_n     <= w_blank_n_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    led_col_shifter #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .PWM_BITS (PWM_BITS)
    ) u_col_shifter (
        .i_clk     (i_clk),
        .i_RESET_n (i_RESET_n),
        .i_abort   (w_abort),
        .i_start   (w_start),
        .i_row     (w_row_nxt),
        .i_plane   (r_plane),
        .o_done    (w_done),
        .fb        (fb),
        .o_sclk    (o_sclk),
        .o_sdata   (o_sdata)
    );

    assign o_latch       = r_latch;
    assign o_blank_n     = r_blank_n;
    assign o_row         = r_row_out;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with ROWS=2, COLS=4, PWM_BITS=2, DWELL=2;
// the frame-buffer model returns (addr+1) truncated to 2 bits, one clock after the read strobe.
module tb_led_scan_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic sclk, sdata, latch, blank_n, row, fs;
    int   total = 0;
    int   bad   = 0;

    logic [2:0] exp_addr [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
    logic       exp_bit  [16] = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0};
    int         exp_latch_cyc [4] = '{12, 27, 44, 59};
    int         exp_blank_len [4] = '{2, 4, 2, 4};

    led_scan_ctrl_if #(.ADDR_W(3), .DATA_W(2)) fb ();

    led_scan_ctrl #(
        .ROWS(2), .COLS(4), .PWM_BITS(2), .DWELL(2)
    ) dut (
        .i_clk         (clk),
        .i_RESET_n     (rst_n),
        .i_ena         (ena),
        .fb            (fb),
        .o_sclk        (sclk),
        .o_sdata       (sdata),
        .o_latch       (latch),
        .o_blank_n     (blank_n),
        .o_row         (row),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    // Data is present only in the cycle right after the strobe.
    always @(posedge clk) fb.rd_data <= fb.rd_en ? (fb.rd_addr[1:0] + 2'd1) : 2'd0;

    function automatic logic [9:0] outs();
        return {fb.rd_en, fb.rd_addr, sclk, sdata, latch, blank_n, row, fs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n_rd, n_rise, n_latch, n_blank, blank_len, n_fs;
        logic prev_sclk, prev_sdata, pe;

        rst_n = 1'b0;
        ena   = 1'b0;

        // Reset, then enable held low: everything quiet.
        for (int i = 0; i < 20; i++) begin
            if (i == 3) rst_n = 1'b1;
            tick();
            chk("idle_zero", 32'(outs()), 0);
        end

        // Full frame with enable held high.
        ena = 1'b1;
        n_rd = 0; n_rise = 0; n_latch = 0; n_blank = 0; blank_len = 0; n_fs = 0;
        prev_sclk = 1'b0; prev_sdata = 1'b0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (c == 0) begin
                chk("first_fs", 32'(fs), 1);
                chk("first_rd_en", 32'(fb.rd_en), 1);
            end else if (fs) begin
                n_fs++;
            end
            if (fb.rd_en) begin
                chk("rd_addr", 32'(fb.rd_addr), 32'(exp_addr[n_rd % 16]));
                n_rd++;
            end
            if (sclk && !prev_sclk) begin
                chk("sdata_at_rise", 32'(sdata), 32'(exp_bit[n_rise % 16]));
                chk("sdata_setup", 32'(sdata), 32'(prev_sdata));
                n_rise++;
            end
            if (latch) begin
                chk("latch_cycle", 32'(c), 32'(exp_latch_cyc[n_latch % 4]));
                chk("latch_row", 32'(row), 32'(n_latch / 2));
                n_latch++;
            end
            if (blank_n) begin
                chk("row_while_lit", 32'(row), 32'(n_blank / 2));
                blank_len++;
            end else if (blank_len != 0) begin
                chk("blank_len", 32'(blank_len), 32'(exp_blank_len[n_blank % 4]));
                n_blank++;
                blank_len = 0;
            end
            prev_sclk  = sclk;
            prev_sdata = sdata;
        end
        tick();
        chk("frame2_fs", 32'(fs), 1);
        chk("frame2_rd", 32'({fb.rd_en, fb.rd_addr}), 32'(4'b1000));
        chk("last_blank_len", 32'(blank_len), 4);
        chk("blank_n_after_frame", 32'(blank_n), 0);
        chk("extra_fs", 32'(n_fs), 0);
        chk("rd_count", 32'(n_rd), 16);
        chk("rise_count", 32'(n_rise), 16);
        chk("latch_count", 32'(n_latch), 4);

        // Abort during SHIFT of row 1, then re-enable.
        repeat (35) tick();
        chk("pre_abort_rd", 32'({fb.rd_en, fb.rd_addr}), 32'(4'b1101));
        ena = 1'b0;
        tick();
        chk("abort_zero", 32'(outs()), 0);
        tick();
        chk("abort_hold_zero", 32'(outs()), 0);
        ena = 1'b1;
        tick();
        chk("reenable_fs", 32'(fs), 1);
        chk("reenable_rd", 32'({fb.rd_en, fb.rd_addr}), 32'(4'b1000));

        // Asynchronous reset during DISPLAY of row 1.
        repeat (45) tick();
        chk("lit_row1", 32'({blank_n, row}), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        chk("async_blank", 32'(blank_n), 0);
        chk("async_row", 32'(row), 0);
        chk("async_all_zero", 32'(outs()), 0);
        tick();
        chk("reset_hold_zero", 32'(outs()), 0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_fs", 32'(fs), 1);
        chk("post_reset_rd", 32'({fb.rd_en, fb.rd_addr}), 32'(4'b1000));
        repeat (12) tick();
        chk("post_reset_latch", 32'({latch, row}), 32'(2'b10));
        tick();
        chk("post_reset_lit", 32'({blank_n, row}), 32'(2'b10));

        // Enable toggling every clock.
        ena = 1'b0;
        tick();
        tick();
        chk("toggle_start_zero", 32'(outs()), 0);
        for (int i = 0; i < 10; i++) begin
            ena = (i % 2 == 0);
            pe  = ena;
            tick();
            chk("toggle_fs_rd_en", 32'({fs, fb.rd_en}), 32'({pe, pe}));
            chk("toggle_quiet", 32'({sclk, latch, blank_n, fb.rd_addr}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
